// File: rtl/display_arbiter_pkg.sv
// rtl/display_arbiter_pkg.sv - shared FSM encodings and digit geometry for the display arbiter
package display_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DWELL = 2'd1;
   localparam logic [1:0] ST_FREE  = 2'd2;

   localparam int DIGITS     = 4;
   localparam int NIBBLE     = 4;
   localparam int DIGIT_BITS = DIGITS * NIBBLE;

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - blink half-period counter and on/off phase
// phase_next is the value phase takes on the coming edge, so callers can register outputs in step with it.
module blink_timer #(
   parameter int BLINK_HALF = 250
) (
   input  logic clk_1kHz,
   input  logic rst_,
   input  logic restart,
   output logic phase_next,
   output logic phase
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((BLINK_HALF > 0) ? BLINK_HALF - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q;

   always_comb begin
      cnt_d      = cnt_q + CW'(1);
      phase_next = phase_q;
      if (restart) begin
         cnt_d      = '0;
         phase_next = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d      = '0;
         phase_next = ~phase_q;
      end
   end

   always_ff @(posedge clk_1kHz or negedge rst_) begin
      if (!rst_) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_next;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - shares the 4-digit display among requesters by fixed priority
// A new owner keeps the display for at least MIN_DWELL cycles unless it releases it first.
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int MIN_DWELL  = 500,
   parameter int BLINK_HALF = 250
) (
   input  logic                         clk_1kHz,
   input  logic                         rst_,
   input  logic [NREQ-1:0]              req,
   input  logic [DIGIT_BITS*NREQ-1:0]   req_bin,
   input  logic [DIGITS*NREQ-1:0]       req_en,
   input  logic [DIGITS*NREQ-1:0]       req_dp,
   input  logic [DIGITS*NREQ-1:0]       req_blink,
   output logic [NIBBLE-1:0]            bin0,
   output logic [NIBBLE-1:0]            bin1,
   output logic [NIBBLE-1:0]            bin2,
   output logic [NIBBLE-1:0]            bin3,
   output logic [DIGITS-1:0]            en,
   output logic [DIGITS-1:0]            dpin,
   output logic [NREQ-1:0]              grant,
   output logic                         active
);

   localparam int OW = $clog2(NREQ);
   localparam int DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL + 1) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'((MIN_DWELL > 1) ? MIN_DWELL - 1 : 0);
   // With a dwell of 0 or 1 cycles a fresh grant is preemptible on the very next edge.
   localparam logic [1:0] ST_GRANTED = (MIN_DWELL > 1) ? ST_DWELL : ST_FREE;

   logic [1:0]            state_q, state_d;
   logic [OW-1:0]         owner_q, owner_d;
   logic [DW-1:0]         dwell_q, dwell_d;
   logic [NREQ-1:0]       grant_q, grant_d;
   logic [DIGIT_BITS-1:0] bins_q;
   logic [DIGITS-1:0]     en_q, dp_q;
   logic                  active_q;

   logic [OW-1:0]         win;
   logic                  any_req, owner_req, switch_now, restart;
   logic                  phase_next, blink_phase_unused;
   logic [DIGIT_BITS-1:0] sel_bin;
   logic [DIGITS-1:0]     sel_en, sel_dp, sel_blink;

   always_comb begin
      win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) win = OW'(i);
      end
   end

   assign any_req   = |req;
   assign owner_req = |(req & grant_q);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      dwell_d    = dwell_q;
      switch_now = 1'b0;
      case (state_q)
         ST_DWELL: begin
            if (!owner_req) begin
               switch_now = 1'b1;
            end else begin
               dwell_d = dwell_q + DW'(1);
               if (dwell_d == DWELL_LAST) state_d = ST_FREE;
            end
         end
         ST_FREE: begin
            if (!owner_req || (win != owner_q)) switch_now = 1'b1;
         end
         default: begin
            if (any_req) switch_now = 1'b1;
            else         state_d    = ST_IDLE;
         end
      endcase
      if (switch_now) begin
         dwell_d = '0;
         if (any_req) begin
            state_d = ST_GRANTED;
            owner_d = win;
         end else begin
            state_d = ST_IDLE;
            owner_d = '0;
         end
      end
   end

   assign restart = switch_now;

   always_comb begin
      grant_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_d[i] = (state_d != ST_IDLE) && (owner_d == OW'(i));
      end
   end

   // Mux on the next-state grant so data and grant change on the same edge; idle selects nothing.
   always_comb begin
      sel_bin   = '0;
      sel_en    = '0;
      sel_dp    = '0;
      sel_blink = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_d[i]) begin
            sel_bin   = req_bin[DIGIT_BITS*i +: DIGIT_BITS];
            sel_en    = req_en[DIGITS*i +: DIGITS];
            sel_dp    = req_dp[DIGITS*i +: DIGITS];
            sel_blink = req_blink[DIGITS*i +: DIGITS];
         end
      end
   end

   blink_timer #(
      .BLINK_HALF (BLINK_HALF)
   ) u_blink (
      .clk_1kHz   (clk_1kHz),
      .rst_       (rst_),
      .restart    (restart),
      .phase_next (phase_next),
      .phase      (blink_phase_unused)
   );

   always_ff @(posedge clk_1kHz or negedge rst_) begin
      if (!rst_) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         dwell_q  <= '0;
         grant_q  <= '0;
         bins_q   <= '0;
         en_q     <= '0;
         dp_q     <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         dwell_q  <= dwell_d;
         grant_q  <= grant_d;
         bins_q   <= sel_bin;
         en_q     <= sel_en & ~(sel_blink & {DIGITS{phase_next}});
         dp_q     <= sel_dp;
         active_q <= |grant_d;
      end
   end

   assign bin0   = bins_q[0*NIBBLE +: NIBBLE];
   assign bin1   = bins_q[1*NIBBLE +: NIBBLE];
   assign bin2   = bins_q[2*NIBBLE +: NIBBLE];
   assign bin3   = bins_q[3*NIBBLE +: NIBBLE];
   assign en     = en_q;
   assign dpin   = dp_q;
   assign grant  = grant_q;
   assign active = active_q;

endmodule
